// File: rtl/noc_link_pipe.sv
// Credit-based unidirectional mesh link: retiming stages feeding a first-word
// fall-through receive FIFO, with delivery/stall statistics and a border tie-off mode.
module noc_link_pipe #(
    parameter int FLIT_WIDTH = 32,
    parameter int STAGES     = 2,
    parameter int BUF_DEPTH  = 8,
    parameter int GROUNDED   = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_i,
    input  logic [FLIT_WIDTH-1:0] data_i,
    output logic                  credit_o,
    output logic                  tx_o,
    output logic [FLIT_WIDTH-1:0] data_o,
    input  logic                  credit_i,
    output logic [CNT_WIDTH-1:0]  flit_count,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic                  overflow_err
);

    generate
        if (GROUNDED != 0) begin : g_gnd
            logic unused;
            assign unused       = ^{clock, reset, rx_i, data_i, credit_i};
            assign credit_o     = 1'b0;
            assign tx_o         = 1'b0;
            assign data_o       = '0;
            assign flit_count   = '0;
            assign stall_count  = '0;
            assign overflow_err = 1'b0;
        end else begin : g_link
            localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
            localparam int CW = $clog2(BUF_DEPTH + 1);

            logic                  accept, pop, push;
            logic [FLIT_WIDTH-1:0] push_data;
            logic [FLIT_WIDTH-1:0] mem [BUF_DEPTH];
            logic [PW-1:0]         wr_ptr, rd_ptr;
            logic [CW-1:0]         cnt, occ;
            logic [CW:0]           occ_next;

            assign accept   = rx_i & credit_o;
            assign pop      = tx_o & credit_i;
            assign tx_o     = (cnt != '0);
            assign data_o   = tx_o ? mem[rd_ptr] : '0;
            // occ counts pipe stages too, so every flit in flight already owns a buffer slot
            assign occ_next = (CW+1)'(occ) + (CW+1)'(accept) - (CW+1)'(pop);

            if (STAGES > 0) begin : g_pipe
                logic [STAGES:1]                 vld_pipe;
                logic [STAGES:1][FLIT_WIDTH-1:0] dat_pipe;

                always_ff @(posedge clock) begin
                    if (reset) begin
                        vld_pipe <= '0;
                        dat_pipe <= '0;
                    end else begin
                        vld_pipe[1] <= accept;
                        dat_pipe[1] <= data_i;
                        for (int s = 2; s <= STAGES; s++) begin
                            vld_pipe[s] <= vld_pipe[s-1];
                            dat_pipe[s] <= dat_pipe[s-1];
                        end
                    end
                end

                assign push      = vld_pipe[STAGES];
                assign push_data = dat_pipe[STAGES];
            end else begin : g_nopipe
                assign push      = accept;
                assign push_data = data_i;
            end

            always_ff @(posedge clock) begin
                if (push) mem[wr_ptr] <= push_data;
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    wr_ptr       <= '0;
                    rd_ptr       <= '0;
                    cnt          <= '0;
                    occ          <= '0;
                    credit_o     <= 1'b0;
                    flit_count   <= '0;
                    stall_count  <= '0;
                    overflow_err <= 1'b0;
                end else begin
                    if (push)
                        wr_ptr <= (wr_ptr == PW'(BUF_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
                    if (pop)
                        rd_ptr <= (rd_ptr == PW'(BUF_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
                    cnt      <= cnt + CW'(push) - CW'(pop);
                    occ      <= occ_next[CW-1:0];
                    credit_o <= (occ_next < (CW+1)'(BUF_DEPTH));
                    if (rx_i && !credit_o)
                        overflow_err <= 1'b1;
                    if (pop)
                        flit_count <= flit_count + CNT_WIDTH'(1);
                    if (tx_o && !credit_i && (stall_count != '1))
                        stall_count <= stall_count + CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_noc_link_pipe.sv
// Directed bench for noc_link_pipe: queue scoreboard per link instance, plus a
// grounded instance under random inputs and a narrow-counter, zero-stage instance.
module tb_noc_link_pipe;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // main link: defaults (STAGES=2, BUF_DEPTH=8)
    logic        rx_i, credit_i, credit_o, tx_o, overflow_err;
    logic [31:0] data_i, data_o;
    logic [15:0] flit_count, stall_count;

    // narrow counters, no retiming stages
    logic        rx_c, credit_ic, credit_oc, tx_c, ovf_c;
    logic [31:0] data_c, data_oc;
    logic [3:0]  flit_c, stall_c;

    // border tie-off
    logic        rx_g, credit_ig, credit_og, tx_g, ovf_g;
    logic [31:0] data_g, data_og;
    logic [15:0] flit_g, stall_g;

    noc_link_pipe dut (
        .clock(clock), .reset(reset), .rx_i(rx_i), .data_i(data_i), .credit_o(credit_o),
        .tx_o(tx_o), .data_o(data_o), .credit_i(credit_i), .flit_count(flit_count),
        .stall_count(stall_count), .overflow_err(overflow_err));

    noc_link_pipe #(.STAGES(0), .BUF_DEPTH(2), .CNT_WIDTH(4)) dut_c (
        .clock(clock), .reset(reset), .rx_i(rx_c), .data_i(data_c), .credit_o(credit_oc),
        .tx_o(tx_c), .data_o(data_oc), .credit_i(credit_ic), .flit_count(flit_c),
        .stall_count(stall_c), .overflow_err(ovf_c));

    noc_link_pipe #(.GROUNDED(1)) dut_g (
        .clock(clock), .reset(reset), .rx_i(rx_g), .data_i(data_g), .credit_o(credit_og),
        .tx_o(tx_g), .data_o(data_og), .credit_i(credit_ig), .flit_count(flit_g),
        .stall_count(stall_g), .overflow_err(ovf_g));

    logic [31:0] qm[$];
    logic [31:0] qc[$];
    int          gbad = 0;
    int          gsamples = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // scoreboards: every delivered flit must match the oldest expected one
    always @(negedge clock) begin
        if (!reset && tx_o && credit_i) begin
            check("sb_main_expected", qm.size() != 0, 1);
            if (qm.size() != 0) check("sb_main_data", data_o, qm.pop_front());
        end
        if (!reset && tx_c && credit_ic) begin
            check("sb_c_expected", qc.size() != 0, 1);
            if (qc.size() != 0) check("sb_c_data", data_oc, qc.pop_front());
        end
        gsamples++;
        if ({credit_og, tx_g, data_og, flit_g, stall_g, ovf_g} !== '0) gbad++;
    end

    initial begin
        rx_g = 0; data_g = 0; credit_ig = 0;
        forever begin
            @(posedge clock);
            #1;
            rx_g      = 1'($urandom);
            credit_ig = 1'($urandom);
            data_g    = $urandom;
        end
    end

    initial begin
        int gaps, cred_bad, txs;
        rx_i = 0; data_i = 0; credit_i = 0;
        rx_c = 0; data_c = 0; credit_ic = 0;

        // reset held 3 cycles
        repeat (3) begin
            step();
            check("rst_credit", credit_o, 0);
            check("rst_tx", tx_o, 0);
            check("rst_data", data_o, 0);
            check("rst_flit", flit_count, 0);
            check("rst_stall", stall_count, 0);
            check("rst_ovf", overflow_err, 0);
        end
        reset = 0;
        step();
        check("idle_credit", credit_o, 1);
        check("idle_tx", tx_o, 0);

        // latency: accept at cycle 0, visible at cycle 3 only
        credit_i = 1;
        rx_i = 1; data_i = 32'hCAFE0001; qm.push_back(32'hCAFE0001);
        step();
        rx_i = 0; data_i = 0;
        check("lat_c1_tx", tx_o, 0);
        step();
        check("lat_c2_tx", tx_o, 0);
        step();
        check("lat_c3_tx", tx_o, 1);
        check("lat_c3_data", data_o, 32'hCAFE0001);
        step();
        check("lat_c4_tx", tx_o, 0);
        check("lat_flit", flit_count, 1);

        // fill with downstream blocked: only 1..8 accepted
        credit_i = 0;
        for (int i = 1; i <= 12; i++) begin
            rx_i = 1; data_i = i;
            check("fill_credit", credit_o, (i <= 8));
            if (i == 9) check("ovf_before", overflow_err, 0);
            if (i == 12) check("ovf_set", overflow_err, 1);
            if (i <= 8) qm.push_back(i);
            step();
        end
        rx_i = 0; data_i = 0;
        check("full_stall", stall_count, 9);
        check("full_credit", credit_o, 0);
        check("full_tx", tx_o, 1);
        check("full_head", data_o, 1);
        credit_i = 1;
        step();
        check("credit_return", credit_o, 1);
        check("stall_hold", stall_count, 9);
        repeat (7) step();
        check("drain_tx", tx_o, 0);
        check("drain_flit", flit_count, 9);

        // 100-flit stream, one per cycle with no gaps
        gaps = 0; cred_bad = 0;
        for (int k = 0; k < 103; k++) begin
            if (k < 100) begin
                rx_i = 1; data_i = 32'h1000 + k; qm.push_back(32'h1000 + k);
                if (!credit_o) cred_bad++;
            end else begin
                rx_i = 0; data_i = 0;
            end
            if (k >= 3 && !tx_o) gaps++;
            step();
        end
        check("stream_credit_drops", cred_bad, 0);
        check("stream_gaps", gaps, 0);
        check("stream_tx_end", tx_o, 0);
        check("stream_flit", flit_count, 109);
        check("ovf_sticky", overflow_err, 1);

        // reset with 5 flits in flight: none may emerge
        credit_i = 0;
        for (int k = 0; k < 5; k++) begin
            rx_i = 1; data_i = 32'hDEAD0000 + k;
            step();
        end
        rx_i = 0; data_i = 0;
        reset = 1;
        step();
        reset = 0;
        check("mid_rst_tx", tx_o, 0);
        check("mid_rst_data", data_o, 0);
        check("mid_rst_flit", flit_count, 0);
        check("mid_rst_stall", stall_count, 0);
        check("mid_rst_ovf", overflow_err, 0);
        credit_i = 1;
        txs = 0;
        repeat (10) begin
            step();
            if (tx_o) txs++;
        end
        check("mid_rst_no_delivery", txs, 0);
        check("mid_rst_flit_after", flit_count, 0);

        // zero-stage link, 4-bit counter wraps after 17 pops
        credit_ic = 1;
        for (int k = 0; k < 17; k++) begin
            rx_c = 1; data_c = 32'h500 + k; qc.push_back(32'h500 + k);
            if (k == 1) begin
                check("c_lat_tx", tx_c, 1);
                check("c_lat_data", data_oc, 32'h500);
            end
            step();
        end
        rx_c = 0; data_c = 0;
        repeat (2) step();
        check("c_tx_end", tx_c, 0);
        check("c_flit_wrap", flit_c, 1);

        check("main_queue_drained", qm.size(), 0);
        check("c_queue_drained", qc.size(), 0);
        check("grounded_sampled", gsamples > 100, 1);
        check("grounded_outputs", gbad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
